// File: rtl/two_to_one_mux.sv
// ============================================================================
// Module  : two_to_one_mux
// Brief   : WIDTH-bit word-wide 2:1 mux with optional registered copy (out_q).
// Revision: 1.0
// ============================================================================
`default_nettype none

module two_to_one_mux #(
  parameter int WIDTH   = 32,
  parameter bit REG_OUT = 1'b1
) (
  output logic [WIDTH-1:0] out,
  input  logic             select,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] out_q
);

  // A ternary (not an if/else) so an unknown select merges the inputs bitwise.
  assign out = select ? in1 : in0;

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] out_d;
      logic [WIDTH-1:0] out_q_q;

      assign out_d = out;

      always_ff @(posedge clock) begin
        if (reset) begin
          out_q_q <= '0;
        end else begin
          out_q_q <= out_d;
        end
      end

      assign out_q = out_q_q;
    end else begin : g_noreg
      assign out_q = '0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_two_to_one_mux.sv
// ============================================================================
// Module  : tb_two_to_one_mux
// Brief   : Self-checking bench for two_to_one_mux, incl. a 5-stage SRA chain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_two_to_one_mux;

  localparam int c_WIDTH = 32;

  logic                clk;
  logic                rst;
  logic                sel;
  logic [c_WIDTH-1:0]  in0;
  logic [c_WIDTH-1:0]  in1;
  wire  [c_WIDTH-1:0]  w_out;
  wire  [c_WIDTH-1:0]  w_out_q;

  int n_tests;
  int n_fail;

  two_to_one_mux #(.WIDTH(c_WIDTH), .REG_OUT(1'b1)) u_dut (
    .out    (w_out),
    .select (sel),
    .in0    (in0),
    .in1    (in1),
    .clock  (clk),
    .reset  (rst),
    .out_q  (w_out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic right shifter built from five chained instances.
  logic [31:0] sra_a;
  logic [4:0]  sra_shamt;
  wire  [31:0] w_st [0:5];
  wire  [31:0] w_st_q [0:4];

  assign w_st[0] = sra_a;

  genvar k;
  generate
    for (k = 0; k < 5; k++) begin : g_sra
      localparam int c_SH = 1 << k;
      wire [31:0] w_shifted;
      assign w_shifted = {{c_SH{w_st[k][31]}}, w_st[k][31:c_SH]};
      two_to_one_mux #(.WIDTH(32), .REG_OUT(1'b0)) u_stage (
        .out    (w_st[k+1]),
        .select (sra_shamt[k]),
        .in0    (w_st[k]),
        .in1    (w_shifted),
        .clock  (clk),
        .reset  (rst),
        .out_q  (w_st_q[k])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mux(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (s) return b;
    return a;
  endfunction

  function automatic logic [31:0] ref_sra(input logic [31:0] a, input logic [4:0] n);
    return 32'($signed(a) >>> n);
  endfunction

  logic [31:0] exp_q;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    sel       = 1'b0;
    in0       = '0;
    in1       = '0;
    sra_a     = '0;
    sra_shamt = '0;

    @(posedge clk); #1;
    check("reset_out_q", w_out_q, 32'h0);

    // Combinational path: no clock edge between drive and check.
    sel = 1'b0; in0 = 32'h12345678; in1 = 32'hFFFFFFFF; #1;
    check("comb_sel0", w_out, 32'h12345678);
    sel = 1'b1; in0 = 32'h00000000; in1 = 32'hDEADBEEF; #1;
    check("comb_sel1", w_out, 32'hDEADBEEF);
    sel = 1'b0; #1;
    check("comb_toggle", w_out, 32'h00000000);

    sra_a = 32'h80000000; sra_shamt = 5'd31; #1;
    check("sra_neg31", w_st[5], 32'hFFFFFFFF);
    sra_a = 32'h7FFFFFFF; sra_shamt = 5'd4; #1;
    check("sra_pos4", w_st[5], 32'h07FFFFFF);
    for (int i = 0; i < 40; i++) begin
      sra_a     = $urandom;
      sra_shamt = 5'($urandom_range(0, 31));
      #1;
      check("sra_rand", w_st[5], ref_sra(sra_a, sra_shamt));
    end

    // Reset wins over data; out stays live during reset.
    @(negedge clk);
    rst = 1'b1; sel = 1'b1; in0 = 32'h13579BDF; in1 = 32'hAAAA5555;
    @(posedge clk); #1;
    check("rst_out_q", w_out_q, 32'h0);
    check("rst_out", w_out, 32'hAAAA5555);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_q", w_out_q, 32'hAAAA5555);

    sel = 1'bx; in0 = 32'h0F0F0F0F; in1 = 32'h0F0F0F0F; #1;
    check("selx_agree", w_out, 32'h0F0F0F0F);
    sel = 1'b0; #1;

    // Random sweep: out vs same-cycle model, out_q vs previous-cycle model.
    exp_q = ref_mux(sel, in0, in1);
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #1;
      check("rand_out_q", w_out_q, exp_q);
      sel = i[0] ^ 1'($urandom);
      in0 = $urandom;
      in1 = $urandom;
      rst = ($urandom_range(0, 15) == 0);
      #1;
      check("rand_out", w_out, ref_mux(sel, in0, in1));
      exp_q = rst ? 32'h0 : ref_mux(sel, in0, in1);
    end
    @(posedge clk); #1;
    check("final_out_q", w_out_q, exp_q);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
